// File: rtl/gray2bin_arbiter_pkg.sv
// Shared sizing helpers for the gray2bin arbiter and its neighbours.
// Index widths never drop below one bit, even for tiny requester counts.
package gray2bin_arbiter_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic int id_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        assign bin[j] = ^gray[WIDTH-1:j];
    end

endmodule

// File: rtl/gray2bin_arbiter.sv
// Round-robin front end sharing one Gray decoder among NREQ requesters.
// Grant and capture in one cycle, registered decode in the next.
module gray2bin_arbiter
    import gray2bin_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] gray_in,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      bin_out,
    output logic                  bin_valid,
    output logic [ID_W-1:0]       bin_id
);

    localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(NREQ);
    localparam logic [ID_W-1:0] LAST   = ID_W'(NREQ - 1);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  off;
    logic [ID_W-1:0]  gidx;
    logic [ID_W:0]    sum;
    logic [NREQ-1:0]  rot;
    logic             found;
    logic             grant;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_c;
    logic [ID_W-1:0]  id_q;
    logic             v_q;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = ID_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        gidx  = ID_W'(sum);
        grant = found & rst_n;
        ack   = grant ? (NREQ'(1) << gidx) : '0;
    end

    gray2bin #(
        .WIDTH(WIDTH)
    ) u_conv (
        .gray(gray_q),
        .bin (bin_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            gray_q    <= '0;
            id_q      <= '0;
            v_q       <= 1'b0;
            bin_out   <= '0;
            bin_id    <= '0;
            bin_valid <= 1'b0;
        end else begin
            v_q <= grant;
            if (grant) begin
                gray_q <= gray_in[gidx*WIDTH +: WIDTH];
                id_q   <= gidx;
                ptr    <= (gidx == LAST) ? '0 : gidx + 1'b1;
            end
            bin_out   <= bin_c;
            bin_id    <= id_q;
            bin_valid <= v_q;
        end
    end

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Randomised and directed bench for gray2bin_arbiter.
// A result scoreboard keyed by due cycle stands in for the pipeline.
module tb_gray2bin_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] gray_in;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      bin_out;
    logic                  bin_valid;
    logic [ID_W-1:0]       bin_id;

    gray2bin_arbiter #(
        .WIDTH(WIDTH),
        .NREQ (NREQ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gray_in  (gray_in),
        .ack      (ack),
        .bin_out  (bin_out),
        .bin_valid(bin_valid),
        .bin_id   (bin_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int id;
        int bin;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   now = 0;
    int   mptr = 0;
    int   last_bin = 0;
    int   last_id = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)",
                     tag, obs, exp, now);
        end
    endtask

    function automatic int g2b(input int g);
        int b;
        b = 0;
        for (int s = 0; s < WIDTH; s++) b = b ^ (g >> s);
        return b & ((1 << WIDTH) - 1);
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & ((1 << WIDTH) - 1);
    endfunction

    task automatic cycle(input logic rn, input logic [NREQ-1:0] r,
                         input logic [NREQ*WIDTH-1:0] g);
        logic [31:0] exp_v;
        logic [31:0] exp_ack;
        int          k;
        rst_n   = rn;
        req     = r;
        gray_in = g;
        now++;
        if (!rn) begin
            sb.delete();
            last_bin = 0;
            last_id  = 0;
            mptr     = 0;
        end
        @(negedge clk);
        exp_v = 0;
        if (sb.size() > 0 && sb[0].due == now) begin
            exp_v    = 1;
            last_bin = sb[0].bin;
            last_id  = sb[0].id;
            void'(sb.pop_front());
        end
        check("bin_valid", {31'b0, bin_valid}, exp_v);
        check("bin_out", 32'(bin_out), 32'(last_bin));
        check("bin_id", 32'(bin_id), 32'(last_id));
        exp_ack = 0;
        if (rn) begin
            for (int i = 0; i < NREQ; i++) begin
                k = (mptr + i) % NREQ;
                if (r[k]) begin
                    exp_ack = 32'(1) << k;
                    sb.push_back('{now + 2, k,
                                   g2b(int'(g[k*WIDTH +: WIDTH]))});
                    mptr = (k + 1) % NREQ;
                    break;
                end
            end
        end
        check("ack", 32'(ack), exp_ack);
        @(posedge clk);
        #1;
    endtask

    logic [NREQ*WIDTH-1:0] gw;
    logic [NREQ*WIDTH-1:0] rg;

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        gray_in = '0;
        gw      = '0;
        rg      = '0;

        cycle(1'b0, 4'b1111, '0);
        cycle(1'b0, 4'b1111, '0);
        cycle(1'b1, 4'b1111, '0);
        cycle(1'b1, 4'b0000, '0);
        cycle(1'b1, 4'b0000, '0);
        cycle(1'b1, 4'b0000, '0);

        gw = '0;
        gw[2*WIDTH +: WIDTH] = 4'b1100;
        cycle(1'b1, 4'b0100, gw);
        cycle(1'b1, 4'b0000, gw);
        cycle(1'b1, 4'b0000, gw);
        cycle(1'b1, 4'b0000, gw);

        cycle(1'b0, 4'b0000, '0);
        for (int i = 0; i < NREQ; i++) gw[i*WIDTH +: WIDTH] = WIDTH'(b2g(i));
        for (int n = 0; n < 5; n++) cycle(1'b1, 4'b1111, gw);
        cycle(1'b1, 4'b1111, gw);
        cycle(1'b1, 4'b1111, gw);
        cycle(1'b1, 4'b1001, gw);
        cycle(1'b1, 4'b1001, gw);
        cycle(1'b1, 4'b0000, gw);
        cycle(1'b1, 4'b0000, gw);

        for (int n = 0; n < 16; n++) begin
            gw = '0;
            gw[1*WIDTH +: WIDTH] = WIDTH'(b2g(n));
            cycle(1'b1, 4'b0010, gw);
        end
        cycle(1'b1, 4'b0000, gw);
        cycle(1'b1, 4'b0000, gw);

        cycle(1'b1, 4'b0100, gw);
        cycle(1'b0, 4'b1111, gw);
        cycle(1'b1, 4'b1111, gw);
        cycle(1'b1, 4'b0000, gw);
        cycle(1'b1, 4'b0000, gw);

        for (int n = 0; n < 400; n++) begin
            rg = {$urandom, $urandom};
            cycle(($urandom_range(0, 39) != 0),
                  NREQ'($urandom), rg);
        end
        cycle(1'b1, 4'b0000, rg);
        cycle(1'b1, 4'b0000, rg);
        cycle(1'b1, 4'b0000, rg);

        if (sb.size() != 0)
            check("drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
